// File: rtl/grid_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : grid_mem_arbiter_if
// Purpose  : Requester and grid-memory port A bundle for grid_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface grid_mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_gnt;
   logic              vid_rvalid;
   logic [DATA_W-1:0] vid_rdata;

   logic              game_req;
   logic              game_we;
   logic [ADDR_W-1:0] game_addr;
   logic [DATA_W-1:0] game_wdata;
   logic              game_gnt;
   logic              game_rvalid;
   logic [DATA_W-1:0] game_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_we;
   logic [DATA_W-1:0] mem_q;

   modport slave (
      input  vid_req, vid_addr,
      output vid_gnt, vid_rvalid, vid_rdata,
      input  game_req, game_we, game_addr, game_wdata,
      output game_gnt, game_rvalid, game_rdata,
      output mem_addr, mem_data, mem_we,
      input  mem_q
   );

   modport master (
      output vid_req, vid_addr,
      input  vid_gnt, vid_rvalid, vid_rdata,
      output game_req, game_we, game_addr, game_wdata,
      input  game_gnt, game_rvalid, game_rdata,
      input  mem_addr, mem_data, mem_we,
      output mem_q
   );
endinterface
`default_nettype wire

// File: rtl/grid_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : grid_mem_arbiter
// Purpose  : Video/game arbiter for grid memory port A, zero-latency grant,
//            read data steered back one cycle later. Optional macro
//            GRID_ARB_FAIR_EN adds a starvation counter for game logic.
// Revision : 1.0 - initial release
// ============================================================================
module grid_mem_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   grid_mem_arbiter_if.slave bus
);

   localparam logic [DATA_W-1:0] DATA_ZERO = '0;

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("grid_mem_arbiter: STARVE_MAX must be within 1..15");
   end

   logic              vid_gnt;
   logic              game_gnt;
   logic              starved;
   logic              rd_vid_q;
   logic              rd_game_q;
   logic [ADDR_W-1:0] addr_sel;

`ifdef GRID_ARB_FAIR_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt_q;
   logic [3:0] starve_cnt_d;

   assign starved = (starve_cnt_q == STARVE_LIM);

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (game_gnt || !bus.game_req) begin
         starve_cnt_d = 4'd0;
      end else if (vid_gnt && !starved) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= 4'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign starved = 1'b0;
`endif

   // Grants are forced low while reset is held, independent of requests.
   always_comb begin
      vid_gnt  = 1'b0;
      game_gnt = 1'b0;
      if (rst_n) begin
         if (bus.game_req && (!bus.vid_req || starved)) begin
            game_gnt = 1'b1;
         end else if (bus.vid_req) begin
            vid_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      addr_sel = '0;
      if (vid_gnt) begin
         addr_sel = bus.vid_addr;
      end else if (game_gnt) begin
         addr_sel = bus.game_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vid_q  <= 1'b0;
         rd_game_q <= 1'b0;
      end else begin
         rd_vid_q  <= vid_gnt;
         rd_game_q <= game_gnt & ~bus.game_we;
      end
   end

   assign bus.vid_gnt     = vid_gnt;
   assign bus.game_gnt    = game_gnt;
   assign bus.mem_addr    = addr_sel;
   assign bus.mem_we      = game_gnt & bus.game_we;
   assign bus.mem_data    = bus.game_wdata;

   // mem_q is shared; only the requester that owns the pending read sees it.
   assign bus.vid_rvalid  = rd_vid_q;
   assign bus.game_rvalid = rd_game_q;
   assign bus.vid_rdata   = rd_vid_q  ? bus.mem_q : DATA_ZERO;
   assign bus.game_rdata  = rd_game_q ? bus.mem_q : DATA_ZERO;

endmodule
`default_nettype wire

// File: tb/tb_grid_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_grid_mem_arbiter
// Purpose  : Self-checking bench for grid_mem_arbiter with a write-first
//            grid memory model and a read-return scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_mem_arbiter;

   localparam int AW   = 8;
   localparam int DW   = 8;
   localparam int SMAX = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   grid_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   grid_mem_arbiter #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [DW-1:0] cell_init(input int i);
      if (i == 'h12) return 8'h05;
      return 8'(i) ^ 8'hA5;
   endfunction

   // Grid memory: registered read, write-first on a same-cycle write.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] mem_q_r   = '0;
   logic          mem_ready = 1'b0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= cell_init(i);
         mem_ready <= 1'b1;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_data;
         mem_q_r           <= bus.mem_data;
      end else begin
         mem_q_r <= mem[bus.mem_addr];
      end
   end
   assign bus.mem_q = mem_q_r;

   typedef struct {
      logic          vr;
      logic [AW-1:0] va;
      logic          gr;
      logic          gw;
      logic [AW-1:0] ga;
      logic [DW-1:0] gd;
      logic          evg;
      logic          egg;
   } vec_t;

   typedef struct {
      logic          is_game;
      logic [DW-1:0] data;
   } rd_t;

   logic [DW-1:0] model [256];
   rd_t           sbq [$];
   vec_t          tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One clock: drive just after posedge, check at negedge, end just after next posedge.
   task automatic step(input logic vr, input logic [AW-1:0] va, input logic gr,
                       input logic gw, input logic [AW-1:0] ga, input logic [DW-1:0] gd,
                       input logic evg, input logic egg, input string tag);
      rd_t           e;
      logic [AW-1:0] exp_addr;
      bus.vid_req    = vr;
      bus.vid_addr   = va;
      bus.game_req   = gr;
      bus.game_we    = gw;
      bus.game_addr  = ga;
      bus.game_wdata = gd;
      @(negedge clk);
      exp_addr = evg ? va : (egg ? ga : '0);
      chk({tag, ".vid_gnt"},  bus.vid_gnt,  evg);
      chk({tag, ".game_gnt"}, bus.game_gnt, egg);
      chk({tag, ".mem_we"},   bus.mem_we,   egg & gw);
      chk({tag, ".mem_addr"}, bus.mem_addr, exp_addr);
      if (egg && gw) chk({tag, ".mem_data"}, bus.mem_data, gd);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({tag, ".vid_rvalid"},  bus.vid_rvalid,  !e.is_game);
         chk({tag, ".game_rvalid"}, bus.game_rvalid, e.is_game);
         chk({tag, ".vid_rdata"},   bus.vid_rdata,   e.is_game ? 8'h00 : e.data);
         chk({tag, ".game_rdata"},  bus.game_rdata,  e.is_game ? e.data : 8'h00);
      end else begin
         chk({tag, ".vid_rvalid"},  bus.vid_rvalid,  1'b0);
         chk({tag, ".game_rvalid"}, bus.game_rvalid, 1'b0);
         chk({tag, ".vid_rdata"},   bus.vid_rdata,   8'h00);
         chk({tag, ".game_rdata"},  bus.game_rdata,  8'h00);
      end
      if (evg)        sbq.push_back('{1'b0, model[va]});
      if (egg && !gw) sbq.push_back('{1'b1, model[ga]});
      if (egg && gw)  model[ga] = gd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic egg;
      for (int i = 0; i < 256; i++) model[i] = cell_init(i);

      //          vr    va     gr    gw    ga     gd     evg   egg
      tbl[0]  = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 8'h07, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 8'h40, 1'b1, 1'b0, 8'h41, 8'h00, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 8'h12, 1'b1, 1'b1, 8'h12, 8'h99, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h12, 8'h99, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 8'h13, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 8'h14, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

      // Reset held with both requesters active.
      bus.vid_req    = 1'b1;
      bus.vid_addr   = 8'h12;
      bus.game_req   = 1'b1;
      bus.game_we    = 1'b1;
      bus.game_addr  = 8'h33;
      bus.game_wdata = 8'hEE;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.vid_gnt",     bus.vid_gnt,     1'b0);
      chk("rst.game_gnt",    bus.game_gnt,    1'b0);
      chk("rst.vid_rvalid",  bus.vid_rvalid,  1'b0);
      chk("rst.game_rvalid", bus.game_rvalid, 1'b0);
      chk("rst.mem_we",      bus.mem_we,      1'b0);
      chk("rst.mem_addr",    bus.mem_addr,    8'h00);
      chk("rst.vid_rdata",   bus.vid_rdata,   8'h00);
      chk("rst.game_rdata",  bus.game_rdata,  8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 8'h12, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, "rel_v");
      step(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, "rel_g");

      for (int k = 0; k < 14; k++)
         step(tbl[k].vr, tbl[k].va, tbl[k].gr, tbl[k].gw, tbl[k].ga, tbl[k].gd,
              tbl[k].evg, tbl[k].egg, $sformatf("vec%0d", k));

      // Continuous contention.
      for (int i = 0; i < 10; i++) begin
`ifdef GRID_ARB_FAIR_EN
         egg = ((i % 5) == 4);
`else
         egg = 1'b0;
`endif
         step(1'b1, 8'(8'h70 + i), 1'b1, 1'b0, 8'h50, 8'h00, !egg, egg,
              $sformatf("cont%0d", i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b1, "cont_drop");

      // Reset in the cycle after a video grant, with the counter part-way up.
      step(1'b1, 8'h60, 1'b1, 1'b0, 8'h51, 8'h00, 1'b1, 1'b0, "rmr_a");
      step(1'b1, 8'h61, 1'b1, 1'b0, 8'h51, 8'h00, 1'b1, 1'b0, "rmr_b");
      rst_n = 1'b0;
      @(negedge clk);
      chk("rmr.vid_rvalid", bus.vid_rvalid, 1'b0);
      chk("rmr.vid_rdata",  bus.vid_rdata,  8'h00);
      chk("rmr.vid_gnt",    bus.vid_gnt,    1'b0);
      chk("rmr.game_gnt",   bus.game_gnt,   1'b0);
      sbq.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
`ifdef GRID_ARB_FAIR_EN
         egg = (i == 4);
`else
         egg = 1'b0;
`endif
         step(1'b1, 8'(8'h62 + i), 1'b1, 1'b0, 8'h51, 8'h00, !egg, egg,
              $sformatf("rmr_post%0d", i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 8'h51, 8'h00, 1'b0, 1'b1, "rmr_drop");
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
